// File: rtl/vid2strm.sv
// vid2strm: converts the raw video bus from the timing/pattern generator into a
// valid/ready pixel stream with start-of-frame (m_tuser) and end-of-line (m_tlast).
// A one-pixel hold stage delays each pixel until the following cycle shows
// whether it ends the line. A first-word-fall-through FIFO then absorbs
// consumer stalls. When the FIFO overflows, the rest of the frame is dropped
// and the block resynchronises on the next vs rising edge.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   hs                  horizontal sync (monitoring only, not used for framing)
//   vs                  vertical sync, rising edge starts a frame
//   vld, rgb            active-pixel qualifier and pixel data (3*PW bits)
//   m_tdata/m_tvalid/m_tready/m_tuser/m_tlast   output pixel stream
//   ovf, ovf_clr        sticky overflow flag and its clear
//   frame_cnt           number of vs rising edges seen (wraps)
//
// Optional feature, macro VID2STRM_LINE_CHECK_EN:
//   line_len            pixel count of the first complete line after each frame start
//   line_err            sticky; set by any later line whose length differs (cleared by ovf_clr)

module vid2strm #(
  parameter int unsigned PW         = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hs,
  input  logic              vs,
  input  logic              vld,
  input  logic [3*PW-1:0]   rgb,
  output logic [3*PW-1:0]   m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [15:0]       frame_cnt
`ifdef VID2STRM_LINE_CHECK_EN
  ,
  output logic              line_err,
  output logic [15:0]       line_len
`endif
);

  localparam int unsigned DW    = 3 * PW;
  localparam int unsigned EW    = DW + 2;          // {sof, eol, pixel}
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic                  vsD;
  logic                  sofPending;
  logic                  drop;
  logic                  holdVld;
  logic                  holdSof;
  logic [DW-1:0]         holdPix;
  logic [EW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [CW-1:0]         count;

  logic                  sofEvt;
  logic                  capture;
  logic                  pushReq;
  logic                  pop;
  logic                  full;
  logic                  pushOk;
  logic                  ovfEvt;
  logic [EW-1:0]         pushEntry;
  logic [EW-1:0]         headEntry;

  // hs is carried for monitoring only; tie it off explicitly.
  logic                  unusedHs;
  assign unusedHs = hs;

  // Capture/push decisions for the current cycle.
  always_comb begin
    sofEvt    = vs & ~vsD;
    capture   = vld & ~drop;
    // Held pixel leaves when a newer pixel replaces it or when vld falls (end of line).
    pushReq   = holdVld & (capture | ~vld);
    pushEntry = {holdSof, ~vld, holdPix};
    pop       = (count != '0) & m_tready;
    full      = (count == CW'(DEPTH));
    pushOk    = pushReq & (~full | pop);
    ovfEvt    = pushReq & full & ~pop;
  end

  // Framing, hold stage, FIFO pointers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsD        <= 1'b0;
      frame_cnt  <= 16'd0;
      sofPending <= 1'b0;
      drop       <= 1'b0;
      holdVld    <= 1'b0;
      holdSof    <= 1'b0;
      holdPix    <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      vsD <= vs;

      if (sofEvt) frame_cnt <= frame_cnt + 16'd1;

      if (capture) sofPending <= 1'b0;
      if (sofEvt)  sofPending <= 1'b1;

      // A frame start always re-arms capture, even if it coincides with an overflow.
      if (ovfEvt) drop <= 1'b1;
      if (sofEvt) drop <= 1'b0;

      if (ovfEvt) begin
        holdVld <= 1'b0;
      end else if (capture) begin
        holdVld <= 1'b1;
        holdSof <= sofPending;
        holdPix <= rgb;
      end else if (pushReq) begin
        holdVld <= 1'b0;
      end

      if (pushOk) wrPtr <= wrPtr + DEPTH_LOG2'(1);
      if (pop)    rdPtr <= rdPtr + DEPTH_LOG2'(1);

      case ({pushOk, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (ovfEvt)       ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // FIFO storage; contents are only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= pushEntry;
  end

  // First-word-fall-through head, forced to zero while empty.
  assign headEntry = mem[rdPtr];
  assign m_tvalid  = (count != '0);
  assign m_tdata   = m_tvalid ? headEntry[DW-1:0] : '0;
  assign m_tlast   = m_tvalid & headEntry[DW];
  assign m_tuser   = m_tvalid & headEntry[DW+1];

`ifdef VID2STRM_LINE_CHECK_EN
  logic [15:0] lineCnt;
  logic [15:0] lineTotal;
  logic        firstLine;
  logic        lineEnd;
  logic        lineMismatch;

  // Line length bookkeeping on pixels that actually enter the FIFO.
  always_comb begin
    lineTotal    = lineCnt + 16'd1;
    lineEnd      = pushOk & pushEntry[DW];
    lineMismatch = lineEnd & ~firstLine & (lineTotal != line_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lineCnt   <= 16'd0;
      firstLine <= 1'b1;
      line_len  <= 16'd0;
      line_err  <= 1'b0;
    end else begin
      if (pushOk) begin
        if (lineEnd) begin
          lineCnt <= 16'd0;
          if (firstLine) begin
            line_len  <= lineTotal;
            firstLine <= 1'b0;
          end
        end else begin
          lineCnt <= lineTotal;
        end
      end
      // A line cut short by an overflow never reaches its end and is not checked.
      if (ovfEvt) lineCnt <= 16'd0;
      if (sofEvt) begin
        lineCnt   <= 16'd0;
        firstLine <= 1'b1;
      end

      if (lineMismatch) line_err <= 1'b1;
      else if (ovf_clr) line_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vid2strm.sv
// Self-checking bench for vid2strm. Instance A uses the default 16-entry FIFO,
// instance B a 4-entry FIFO for the overflow scenarios. Both share the video input.
// Stream beats are logged on the falling edge and compared against tables of
// expected {pixel, tuser, tlast} records.

module tb_vid2strm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs, vld, ovf_clr;
  logic [23:0] rgb;
  logic        treadyA, treadyB;
  logic [23:0] tdataA, tdataB;
  logic        tvalidA, tvalidB, tuserA, tuserB, tlastA, tlastB, ovfA, ovfB;
  logic [15:0] frameCntA, frameCntB;
`ifdef VID2STRM_LINE_CHECK_EN
  logic        lineErrA, lineErrB;
  logic [15:0] lineLenA, lineLenB;
`endif

  always #5 clk = ~clk;

  vid2strm #(.PW(8), .DEPTH_LOG2(4)) dutA (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
    .m_tdata(tdataA), .m_tvalid(tvalidA), .m_tready(treadyA),
    .m_tuser(tuserA), .m_tlast(tlastA), .ovf(ovfA), .ovf_clr(ovf_clr),
    .frame_cnt(frameCntA)
`ifdef VID2STRM_LINE_CHECK_EN
    , .line_err(lineErrA), .line_len(lineLenA)
`endif
  );

  vid2strm #(.PW(8), .DEPTH_LOG2(2)) dutB (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
    .m_tdata(tdataB), .m_tvalid(tvalidB), .m_tready(treadyB),
    .m_tuser(tuserB), .m_tlast(tlastB), .ovf(ovfB), .ovf_clr(ovf_clr),
    .frame_cnt(frameCntB)
`ifdef VID2STRM_LINE_CHECK_EN
    , .line_err(lineErrB), .line_len(lineLenB)
`endif
  );

  typedef struct {
    logic [23:0] rgbIn;
    logic        expUser;
    logic        expLast;
  } vec_t;

  vec_t        tbl[$];
  logic [25:0] qA[$];
  logic [25:0] qB[$];
  int          nTests = 0;
  int          nFail  = 0;
  logic        toggleEn = 1'b0;

  // Beat logger: {tuser, tlast, tdata} for every accepted transfer.
  always @(negedge clk) begin
    if (rst_n && tvalidA && treadyA) qA.push_back({tuserA, tlastA, tdataA});
    if (rst_n && tvalidB && treadyB) qB.push_back({tuserB, tlastB, tdataB});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggleEn) treadyA = ~treadyA;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [23:0] pix(input int f, input int l, input int p);
    return {8'(f), 8'(l), 8'(p + 8'h40)};
  endfunction

  // Expected stream of a frame: nl lines, the last one lastPl pixels long, others pl.
  task automatic build(input int f, input int nl, input int pl, input int lastPl);
    tbl.delete();
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == nl - 1) ? lastPl : pl;
      for (int p = 0; p < len; p++)
        tbl.push_back('{rgbIn: pix(f, l, p), expUser: (l == 0 && p == 0), expLast: (p == len - 1)});
    end
  endtask

  task automatic vs_pulse();
    vs = 1'b1; idle(2);
    vs = 1'b0; idle(2);
  endtask

  // Drive the table's pixels as one frame with 4-cycle horizontal blanking.
  task automatic send_tbl();
    vs_pulse();
    foreach (tbl[i]) begin
      vld = 1'b1; hs = 1'b0; rgb = tbl[i].rgbIn;
      tick();
      if (tbl[i].expLast) begin
        vld = 1'b0; hs = 1'b1; rgb = '0;
        idle(4);
      end
    end
    hs = 1'b0;
    idle(4);
  endtask

  task automatic cmp_tbl(input string nm, input int which, input int start);
    int got;
    logic [25:0] b;
    got = (which == 0) ? qA.size() - start : qB.size() - start;
    chk({nm, "_beats"}, 32'(got), 32'(tbl.size()));
    for (int i = 0; i < tbl.size() && i < got; i++) begin
      b = (which == 0) ? qA[start + i] : qB[start + i];
      chk($sformatf("%s_beat%0d", nm, i), 32'(b), 32'({tbl[i].expUser, tbl[i].expLast, tbl[i].rgbIn}));
    end
  endtask

  // One 8-pixel line into B with ready low; overflow hits when pixel 4 is pushed.
  task automatic ovf_line(input int f, input int clrAt, input logic preOvf);
    vs_pulse();
    for (int i = 0; i < 8; i++) begin
      vld = 1'b1; rgb = pix(f, 0, i); ovf_clr = (i == clrAt);
      tick();
      if (i == 4) chk($sformatf("ovf_before_f%0d", f), 32'(ovfB), 32'(preOvf));
      if (i == 5) chk($sformatf("ovf_set_f%0d", f), 32'(ovfB), 32'd1);
    end
    vld = 1'b0; ovf_clr = 1'b0; rgb = '0;
    idle(4);
  endtask

  initial begin
    int s;
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; vld = 1'b0; rgb = '0; ovf_clr = 1'b0;
    treadyA = 1'b1; treadyB = 1'b1;
    idle(3);

    // Reset state.
    chk("rst_tvalid", 32'(tvalidA), 32'd0);
    chk("rst_tdata", 32'(tdataA), 32'd0);
    chk("rst_tuser", 32'(tuserA), 32'd0);
    chk("rst_tlast", 32'(tlastA), 32'd0);
    chk("rst_ovf", 32'(ovfA), 32'd0);
    chk("rst_frame_cnt", 32'(frameCntA), 32'd0);
    chk("rst_tvalid_b", 32'(tvalidB), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Frame of 4x8 with ready held high.
    build(1, 4, 8, 8);
    s = qA.size();
    send_tbl();
    idle(10);
    cmp_tbl("frame1", 0, s);
    chk("frame1_cnt", 32'(frameCntA), 32'd1);
    chk("frame1_ovf", 32'(ovfA), 32'd0);

    // Same frame shape with ready toggling every cycle.
    build(2, 4, 8, 8);
    s = qA.size();
    toggleEn = 1'b1;
    send_tbl();
    idle(40);
    toggleEn = 1'b0; treadyA = 1'b1;
    idle(2);
    cmp_tbl("frame2_toggle", 0, s);
    chk("frame2_cnt", 32'(frameCntA), 32'd2);
    chk("frame2_ovf", 32'(ovfA), 32'd0);

    // Overflow on the 4-entry instance, then drain: only pixels 0..3, no tlast.
    treadyB = 1'b0;
    s = qB.size();
    ovf_line(3, -1, 1'b0);
    treadyB = 1'b1;
    idle(10);
    chk("ovf_drain_beats", 32'(qB.size() - s), 32'd4);
    for (int i = 0; i < 4 && s + i < qB.size(); i++)
      chk($sformatf("ovf_drain_beat%0d", i), 32'(qB[s + i]), 32'({(i == 0), 1'b0, pix(3, 0, i)}));

    // A line without a new vs edge is still dropped.
    for (int i = 0; i < 8; i++) begin
      vld = 1'b1; rgb = pix(9, 9, i); tick();
    end
    vld = 1'b0; rgb = '0;
    idle(10);
    chk("drop_until_vs", 32'(qB.size() - s), 32'd4);

    // Next frame is delivered intact on B.
    build(4, 1, 8, 8);
    s = qB.size();
    send_tbl();
    idle(10);
    cmp_tbl("frame4_after_ovf", 1, s);

    // Overflow coinciding with ovf_clr keeps ovf set; a lone clear clears it.
    treadyB = 1'b0;
    ovf_line(5, 5, 1'b1);
    treadyB = 1'b1;
    idle(10);
    chk("ovf_sticky", 32'(ovfB), 32'd1);
    ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0; tick();
    chk("ovf_cleared", 32'(ovfB), 32'd0);

    // Reset mid-line with five entries stored in A.
    treadyA = 1'b0;
    vs_pulse();
    for (int i = 0; i < 6; i++) begin
      vld = 1'b1; rgb = pix(7, 0, i); tick();
    end
    chk("pre_reset_tvalid", 32'(tvalidA), 32'd1);
    chk("pre_reset_head", 32'(tdataA), 32'(pix(7, 0, 0)));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_tvalid", 32'(tvalidA), 32'd0);
    chk("mid_reset_frame_cnt", 32'(frameCntA), 32'd0);
    vld = 1'b0; rgb = '0;
    idle(3);
    rst_n = 1'b1;
    treadyA = 1'b1;
    idle(2);
    build(8, 1, 8, 8);
    s = qA.size();
    send_tbl();
    idle(10);
    cmp_tbl("frame_after_reset", 0, s);
    chk("post_reset_frame_cnt", 32'(frameCntA), 32'd1);

`ifdef VID2STRM_LINE_CHECK_EN
    // Lines of 8, 8, 7 pixels flag a length error.
    build(10, 3, 8, 7);
    send_tbl();
    idle(10);
    chk("line_len", 32'(lineLenA), 32'd8);
    chk("line_err_short", 32'(lineErrA), 32'd1);
    ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0; tick();
    build(11, 4, 8, 8);
    send_tbl();
    idle(10);
    chk("line_err_clean", 32'(lineErrA), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
